// File: rtl/mem_port_b_arbiter.sv
// RAM port B owner: round-robin arbitration between two line requesters,
// with reads, full-line writes and read-modify-write for byte-masked writes.
module mem_port_b_arbiter #(
   parameter int ADDR_WIDTH = 17,
   parameter int RAM_WIDTH  = 128,
   localparam int MASK_WIDTH = RAM_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [RAM_WIDTH-1:0]  r0_wdata,
   input  logic [MASK_WIDTH-1:0] r0_wmask,
   output logic                  r0_gnt,
   output logic                  r0_done,
   output logic [RAM_WIDTH-1:0]  r0_rdata,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [RAM_WIDTH-1:0]  r1_wdata,
   input  logic [MASK_WIDTH-1:0] r1_wmask,
   output logic                  r1_gnt,
   output logic                  r1_done,
   output logic [RAM_WIDTH-1:0]  r1_rdata,
   input  logic [RAM_WIDTH-1:0]  dout_b,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic [RAM_WIDTH-1:0]  din_b,
   output logic                  we_b
);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR, RMW_ADDR, RMW_DATA, RMW_WR
   } state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  rr_q, rr_d;
   logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
   logic [RAM_WIDTH-1:0]  din_b_q, din_b_d;
   logic                  we_reg_q, we_reg_d;
   logic [RAM_WIDTH-1:0]  wdata_q, wdata_d;
   logic [MASK_WIDTH-1:0] wmask_q, wmask_d;

   logic                  live;
   logic                  gnt;
   logic                  win;
   logic                  done;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [RAM_WIDTH-1:0]  sel_wdata;
   logic [MASK_WIDTH-1:0] sel_wmask;
   logic [RAM_WIDTH-1:0]  merged;

   // Outputs that cause side effects are killed while frozen or in reset.
   assign live   = rdy & ~rst;
   assign addr_b = addr_b_q;
   assign din_b  = din_b_q;
   assign we_b   = we_reg_q & live;

   assign r0_gnt   = gnt & ~win & live;
   assign r1_gnt   = gnt & win & live;
   assign r0_done  = done & ~owner_q & live;
   assign r1_done  = done & owner_q & live;
   assign r0_rdata = (r0_done && state_q == RD_DATA) ? dout_b : '0;
   assign r1_rdata = (r1_done && state_q == RD_DATA) ? dout_b : '0;

   // Winner select: a lone requester wins, a tie goes to rr_q.
   always_comb begin
      win = r1_req;
      if (r0_req && r1_req) win = rr_q;
      sel_we    = win ? r1_we    : r0_we;
      sel_addr  = win ? r1_addr  : r0_addr;
      sel_wdata = win ? r1_wdata : r0_wdata;
      sel_wmask = win ? r1_wmask : r0_wmask;
   end

   // Byte merge of the old line with the latched write data.
   always_comb begin
      merged = dout_b;
      for (int i = 0; i < MASK_WIDTH; i++) begin
         if (wmask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // Next-state and sequencing of the single in-flight access.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      addr_b_d = addr_b_q;
      din_b_d  = din_b_q;
      we_reg_d = we_reg_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      gnt      = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (r0_req || r1_req) begin
               gnt      = 1'b1;
               owner_d  = win;
               addr_b_d = sel_addr;
               wdata_d  = sel_wdata;
               wmask_d  = sel_wmask;
               if (r0_req && r1_req) rr_d = ~win;
               if (!sel_we) begin
                  state_d = RD_ADDR;
               end else if (&sel_wmask) begin
                  we_reg_d = 1'b1;
                  din_b_d  = sel_wdata;
                  state_d  = WR;
               end else if (~|sel_wmask) begin
                  state_d = WR;
               end else begin
                  state_d = RMW_ADDR;
               end
            end
         end
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         WR: begin
            done     = 1'b1;
            we_reg_d = 1'b0;
            state_d  = IDLE;
         end
         RMW_ADDR: state_d = RMW_DATA;
         RMW_DATA: begin
            din_b_d  = merged;
            we_reg_d = 1'b1;
            state_d  = RMW_WR;
         end
         RMW_WR: begin
            done     = 1'b1;
            we_reg_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers: synchronous reset, everything holds while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         rr_q     <= 1'b0;
         addr_b_q <= '0;
         din_b_q  <= '0;
         we_reg_q <= 1'b0;
         wdata_q  <= '0;
         wmask_q  <= '0;
      end else if (rdy) begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         addr_b_q <= addr_b_d;
         din_b_q  <= din_b_d;
         we_reg_q <= we_reg_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
      end
   end

endmodule
